// File: rtl/req_issue.sv
// Source-side request issuer for a single-bit CDC request path: queues local requests,
// issues one pulse per entry and holds its payload steady until the far side acks or it times out.
module req_issue #(
    parameter int DW  = 32,
    parameter int AW  = 2,
    parameter int TMO = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_in,
    input  logic [DW-1:0] req_data,
    input  logic          ack_in,
    input  logic          err_clr,
    output logic          pulse_out,
    output logic [DW-1:0] hold_data,
    output logic [AW:0]   level,
    output logic          req_full,
    output logic          busy,
    output logic          timeout_err,
    output logic          ovf_err
);
    localparam int DEPTH = 1 << AW;
    localparam int TW    = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   level_q, level_d;
    logic [TW-1:0] timer_q;
    logic [DW-1:0] hold_q;
    logic          tmo_err_q, ovf_q;
    logic          full, wr_en, tmo_hit, retire;

    // Full is judged on the registered level, so a retire in the same cycle cannot make room.
    assign full    = (level_q == (AW+1)'(DEPTH));
    assign wr_en   = req_in && !full;
    assign tmo_hit = (TMO != 0) && (state_q == WAIT) && !ack_in && (timer_q == TW'(TMO - 1));
    assign retire  = (state_q == WAIT) && (ack_in || tmo_hit);
    assign level_d = level_q + (AW+1)'(wr_en) - (AW+1)'(retire);

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= req_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            timer_q   <= '0;
            hold_q    <= '0;
            tmo_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            level_q <= level_d;
            if (wr_en)  wptr_q <= wptr_q + AW'(1);
            if (retire) rptr_q <= rptr_q + AW'(1);

            // Set beats clear when both land in the same cycle.
            ovf_q     <= (req_in && full) || (ovf_q && !err_clr);
            tmo_err_q <= tmo_hit || (tmo_err_q && !err_clr);

            case (state_q)
                IDLE: begin
                    if (level_q != '0) begin
                        hold_q  <= mem_q[rptr_q];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (retire) state_q <= IDLE;
                    else        timer_q <= timer_q + TW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pulse_out   = (state_q == ISSUE);
    assign busy        = (state_q != IDLE);
    assign hold_data   = hold_q;
    assign level       = level_q;
    assign req_full    = full;
    assign timeout_err = tmo_err_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_req_issue.sv
// Directed bench for req_issue: stimulus pushes expected payloads, a negedge monitor
// pops one per pulse_out and checks payload and pulse spacing.
module tb_req_issue;
    localparam int DW = 32, AW = 2, TMO = 8;

    logic          clk = 1'b0, rst = 1'b0;
    logic          req_in = 1'b0, ack_in = 1'b0, err_clr = 1'b0;
    logic [DW-1:0] req_data = '0;
    logic          pulse_out, req_full, busy, timeout_err, ovf_err;
    logic [DW-1:0] hold_data;
    logic [AW:0]   level;

    req_issue #(.DW(DW), .AW(AW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .req_data(req_data), .ack_in(ack_in),
        .err_clr(err_clr), .pulse_out(pulse_out), .hold_data(hold_data), .level(level),
        .req_full(req_full), .busy(busy), .timeout_err(timeout_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int            errs = 0, nchk = 0, cyc = 0, last_pulse = -100;
    logic [DW-1:0] expq [$];
    logic [DW-1:0] exp_hold;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst && pulse_out) begin
            if (expq.size() == 0) begin
                nchk++; errs++;
                $display("FAIL unexpected_pulse: got pulse with hold %0h expected none (cycle %0d)", hold_data, cyc);
            end else begin
                exp_hold = expq.pop_front();
                chk("pulse_hold", hold_data, exp_hold);
            end
            chk("pulse_spacing_ge3", 32'(cyc - last_pulse >= 3), 1);
            last_pulse = cyc;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic push_req(input logic [DW-1:0] d);
        req_in = 1'b1; req_data = d; expq.push_back(d);
    endtask

    // Wait for the next pulse, then ack in the first WAIT cycle.
    task automatic ack_next();
        bit seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (pulse_out) seen = 1'b1;
            step();
        end
        chk("pulse_seen_before_ack", 32'(seen), 1);
        ack_in = 1'b1; step(); ack_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk); #1;
        chk("rst_outputs", {29'd0, pulse_out, busy, req_full}, 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_hold", hold_data, 0);
        chk("rst_flags", {30'd0, timeout_err, ovf_err}, 0);
        rst = 1'b1;
        step();

        // Single request
        push_req(32'hA5A5_0001); step();
        req_in = 1'b0; mid(); chk("t1_level_c1", 32'(level), 1); chk("t1_pulse_c1", 32'(pulse_out), 0); step();
        mid(); chk("t1_pulse_c2", 32'(pulse_out), 1); chk("t1_busy_c2", 32'(busy), 1);
        chk("t1_hold_c2", hold_data, 32'hA5A5_0001); step();
        mid(); chk("t1_pulse_c3", 32'(pulse_out), 0); step(); step(); step();
        ack_in = 1'b1; step(); ack_in = 1'b0;
        mid(); chk("t1_level_c7", 32'(level), 0); chk("t1_busy_c7", 32'(busy), 0);
        chk("t1_hold_kept", hold_data, 32'hA5A5_0001); step();

        // Burst to full, overflow, then drain in order
        for (int i = 1; i <= 4; i++) begin push_req(32'(i)); step(); end
        req_in = 1'b1; req_data = 32'd5;
        mid(); chk("t2_full", 32'(req_full), 1); chk("t2_level4", 32'(level), 4); step();
        req_in = 1'b0; ack_in = 1'b1;
        mid(); chk("t2_ovf", 32'(ovf_err), 1); chk("t2_level_after_drop", 32'(level), 4); step();
        ack_in = 1'b0;
        mid(); chk("t2_level3", 32'(level), 3); chk("t2_not_full", 32'(req_full), 0); step();
        repeat (3) ack_next();
        mid(); chk("t2_drained", 32'(level), 0); chk("t2_ovf_sticky", 32'(ovf_err), 1);
        chk("t2_no_tmo", 32'(timeout_err), 0);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        mid(); chk("t2_ovf_cleared", 32'(ovf_err), 0); step();

        // Timeout: pulse t2, first WAIT t3, flag visible t11
        push_req(32'h0000_0077); step(); req_in = 1'b0;
        repeat (9) step();
        mid(); chk("t3_tmo_c10", 32'(timeout_err), 0); chk("t3_level_c10", 32'(level), 1); step();
        mid(); chk("t3_tmo_c11", 32'(timeout_err), 1); chk("t3_level_c11", 32'(level), 0);
        chk("t3_busy_c11", 32'(busy), 0); step();
        err_clr = 1'b1; step(); err_clr = 1'b0;
        mid(); chk("t3_tmo_cleared", 32'(timeout_err), 0); step();

        // Ack on the timeout cycle wins
        push_req(32'h0000_0088); step(); req_in = 1'b0;
        repeat (9) step();
        ack_in = 1'b1; step(); ack_in = 1'b0;
        mid(); chk("t3b_no_tmo", 32'(timeout_err), 0); chk("t3b_level", 32'(level), 0); step();

        // Write and retire in the same cycle
        push_req(32'h11); step();
        push_req(32'h22); step();
        req_in = 1'b0; step();
        push_req(32'h33); ack_in = 1'b1;
        mid(); chk("t4_level_pre", 32'(level), 2); step();
        req_in = 1'b0; ack_in = 1'b0;
        mid(); chk("t4_level_same", 32'(level), 2); chk("t4_idle", 32'(busy), 0);
        repeat (2) ack_next();
        mid(); chk("t4_drained", 32'(level), 0); step();
        ack_in = 1'b1; step(); ack_in = 1'b0;
        mid(); chk("t4_spur_level", 32'(level), 0); chk("t4_spur_busy", 32'(busy), 0);
        chk("t4_spur_flags", {30'd0, timeout_err, ovf_err}, 0); step();

        // Reset in WAIT with three entries queued
        push_req(32'h41); step();
        push_req(32'h42); step();
        push_req(32'h43); step();
        req_in = 1'b0;
        mid(); chk("t5_level3", 32'(level), 3); chk("t5_busy", 32'(busy), 1); step();
        rst = 1'b0; expq.delete(); #1;
        chk("t5_rst_outputs", {29'd0, pulse_out, busy, req_full}, 0);
        chk("t5_rst_level", 32'(level), 0);
        chk("t5_rst_hold", hold_data, 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        repeat (10) step();
        chk("t5_quiet_level", 32'(level), 0);
        push_req(32'h99); step(); req_in = 1'b0;
        ack_next();
        mid(); chk("t5_new_req_done", 32'(level), 0); step();

        chk("scoreboard_drained", 32'(expq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end
endmodule
